// File: rtl/led_matrix_driver.sv
// led_matrix_driver: row-scanned PWM driver for RGB LED matrices with per-row blanking,
// frame-constant brightness scaling, run/stop enable and selectable pin polarity.
module led_matrix_driver #(
    parameter int ROWS         = 8,
    parameter int COLS         = 16,
    parameter int DEPTH        = 8,
    parameter int REPEAT       = 128,
    parameter int BLANK_CYCLES = 4,
    parameter bit ACTIVE_LOW   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [DEPTH-1:0]          brightness,
    output logic [$clog2(ROWS)-1:0]   row_addr,
    input  logic [COLS*3*DEPTH-1:0]   values,
    output logic                      vsync,
    output logic [ROWS-1:0]           row_sel,
    output logic [COLS-1:0]           col_r,
    output logic [COLS-1:0]           col_g,
    output logic [COLS-1:0]           col_b
);
    localparam int RW = $clog2(ROWS);
    localparam int OW = $clog2(REPEAT) + DEPTH;
    localparam int BW = $clog2(BLANK_CYCLES);
    localparam int PW = 2 * DEPTH + 1;
    localparam int CH = 3 * COLS;
    localparam logic [OW-1:0]   ON_LAST = OW'(REPEAT * (2 ** DEPTH) - 1);
    localparam logic [ROWS-1:0] ROW_OFF = {ROWS{ACTIVE_LOW}};
    localparam logic [COLS-1:0] COL_OFF = {COLS{ACTIVE_LOW}};

    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

    state_t                    state_q;
    logic [RW-1:0]             row_q;
    logic [BW-1:0]             blank_q;
    logic [OW-1:0]             on_q;
    logic [DEPTH-1:0]          bright_q, bright_d;
    logic [CH-1:0][DEPTH-1:0]  sc_q, sc_d;
    logic [CH-1:0]             lit;
    logic [COLS-1:0]           r_d, g_d, b_d;
    logic [ROWS-1:0]           row_sel_q;
    logic [COLS-1:0]           col_r_q, col_g_q, col_b_q;
    logic                      on_last;

    assign on_last  = state_q == ON && on_q == ON_LAST;
    assign vsync    = on_last && row_q == RW'(ROWS - 1);
    assign row_addr = row_q;
    assign row_sel  = row_sel_q;
    assign col_r    = col_r_q;
    assign col_g    = col_g_q;
    assign col_b    = col_b_q;

    // Channel j of values is blue for j%3==0, green for 1, red for 2.
    always_comb begin
        bright_d = row_q == '0 ? brightness : bright_q;
        for (int j = 0; j < CH; j++) begin
            sc_d[j] = DEPTH'((PW'(values[j*DEPTH +: DEPTH]) * (PW'(bright_d) + PW'(1))) >> DEPTH);
            lit[j]  = sc_q[j] > on_q[DEPTH-1:0];
        end
        for (int c = 0; c < COLS; c++) begin
            b_d[c] = lit[3*c];
            g_d[c] = lit[3*c+1];
            r_d[c] = lit[3*c+2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            blank_q   <= '0;
            on_q      <= '0;
            bright_q  <= '0;
            sc_q      <= '0;
            row_sel_q <= ROW_OFF;
            col_r_q   <= COL_OFF;
            col_g_q   <= COL_OFF;
            col_b_q   <= COL_OFF;
        end else begin
            row_sel_q <= state_q == ON ? (ROWS'(1) << row_q) ^ ROW_OFF : ROW_OFF;
            col_r_q   <= state_q == ON ? r_d ^ COL_OFF : COL_OFF;
            col_g_q   <= state_q == ON ? g_d ^ COL_OFF : COL_OFF;
            col_b_q   <= state_q == ON ? b_d ^ COL_OFF : COL_OFF;
            case (state_q)
                IDLE: if (enable) begin
                    state_q <= BLANK;
                    row_q   <= '0;
                    blank_q <= '0;
                end
                BLANK: if (blank_q == BW'(BLANK_CYCLES - 1)) begin
                    state_q  <= ON;
                    on_q     <= '0;
                    sc_q     <= sc_d;
                    bright_q <= bright_d;
                end else begin
                    blank_q <= blank_q + 1'b1;
                end
                ON: if (on_last) begin
                    if (enable) begin
                        state_q <= BLANK;
                        blank_q <= '0;
                        row_q   <= row_q == RW'(ROWS - 1) ? '0 : row_q + 1'b1;
                    end else begin
                        state_q <= IDLE;
                        row_q   <= '0;
                    end
                end else begin
                    on_q <= on_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/led_matrix_driver.md
# led_matrix_driver

Parametrised row-scanned PWM driver for common-row RGB LED matrices. It generalises the fixed 8-row, 16-column, 8-bit display driver to configurable rows, columns, colour depth and repeat count. It adds per-row blanking for ghost suppression, global brightness scaling, a run/stop enable and a selectable output polarity. It sits between the frame buffer, which it addresses one row at a time, and the display connector pins.

## Interface
- ROWS, 8: scanned rows, ≥2
- COLS, 16: columns per row
- DEPTH, 8: bits per colour channel, which is also the PWM resolution
- REPEAT, 128: PWM periods per row visit, ≥1
- BLANK_CYCLES, 4: all-off cycles before each row, ≥2
- ACTIVE_LOW, 1: 1 inverts all `row_sel`/`col_*` pins
- `clk` in 1: single clock
- `rst` in 1: reset, asynchronous and active-high
- `enable` in 1: run the scan when high
- `brightness` in DEPTH: global brightness
- `row_addr` out $clog2(ROWS): row whose data is requested
- `values` in COLS·3·DEPTH: pixel c occupies bits [c·3·DEPTH +: 3·DEPTH], packed red (MSBs), green, blue (LSBs)
- `vsync` out 1: one-cycle pulse at end of frame
- `row_sel` out ROWS: one-hot row drive
- `col_r`, `col_g`, `col_b` out COLS each: column drives

## Operation
- States are IDLE, BLANK and ON.
- Reset
  - State goes to IDLE.
  - `row_addr`=0 and `vsync`=0.
  - All pin registers go to the inactive level: all-ones if ACTIVE_LOW, else zeros.
- IDLE
  - Pins are inactive.
  - When `enable`=1, go to BLANK with row=0 and blank counter=0.
- BLANK
  - Lasts BLANK_CYCLES cycles.
  - Pins are inactive.
  - `row_addr` holds the current row for the whole phase.
  - On the last BLANK cycle:
    - `values` is sampled.
    - If row=0, `brightness` is sampled into the frame brightness register; brightness is therefore constant within a frame.
    - Each channel is stored as scaled = (v·(B+1)) >> DEPTH, computed at 2·DEPTH+1 bits with the top DEPTH bits kept.
    - Consequently B=all-ones gives identity and B=0 gives scaled=0.
  - Then go to ON.
- ON
  - Lasts REPEAT·2^DEPTH cycles.
  - The PWM count p is the low DEPTH bits of the ON counter.
  - A channel is driven iff scaled > p, giving scaled/2^DEPTH duty.
  - Value 0 is never on.
  - `row_sel` bit [row] is active for every ON cycle; all other bits are inactive.
- End of ON, meaning the last ON cycle:
  - If row=ROWS−1, pulse `vsync` for that cycle.
  - If `enable`=1, row = row+1, wrapping from ROWS−1 to 0, then go to BLANK.
  - Otherwise go to IDLE with row=0.
- `enable` is sampled only in IDLE and at end of ON. Deasserting it mid-row completes the current row. Deasserting it in BLANK has no effect until that row's ON phase ends.
- No PWM or row state survives a reset. Asserting `rst` mid-row forces pins inactive asynchronously.

## Timing
- Pin registers have one cycle of latency: pins in cycle n+1 reflect state/p in cycle n.
- The first active `row_sel` appears one cycle after the first ON cycle.
- Pins go inactive one cycle after the first BLANK cycle.
- `vsync` is combinational from state and is asserted in the same cycle as the last ON cycle of row ROWS−1.
- `row_addr` changes on the first BLANK cycle. The source must present valid `values` within BLANK_CYCLES−1 cycles, so a 1-cycle-latency RAM is legal at BLANK_CYCLES ≥ 2.
- Row period is BLANK_CYCLES + REPEAT·2^DEPTH cycles. Frame period is ROWS times the row period.
- The ON counter spans $clog2(REPEAT)+DEPTH bits. The blank counter spans $clog2(BLANK_CYCLES) bits.
- `row_sel` and `col_*` are never active in the same cycle as a BLANK-derived inactive output. There is no overlap between rows.

## Test plan
Unless noted, the bench uses ROWS=4, COLS=2, DEPTH=4, REPEAT=2, BLANK_CYCLES=3, ACTIVE_LOW=1, brightness=15.

- **Reset:** assert `rst` mid-ON.
  - All pins read 1 immediately (asynchronous).
  - `vsync`=0 and `row_addr`=0.
  - The scan restarts at row 0 with BLANK after `rst` drops, provided `enable`=1.
- **Duty:** pixel0 red=5, green=0, blue=15.
  - Per 16-cycle period, `col_r[0]` is low for 5 cycles (p=0..4).
  - `col_g[0]` is never low.
  - `col_b[0]` is low for 15 cycles.
  - This repeats twice per row.
- **Scan order / period:**
  - `row_sel` walks 1110, 1101, 1011, 0111, then back to 1110.
  - Each row is active for 32 cycles, separated by 3 all-high cycles.
  - `vsync` pulses every 140 cycles.
- **Brightness:** value=15 with brightness=7.
  - Scaled = (15·8)>>4 = 7, giving 7 low cycles per period.
  - A brightness change written mid-frame takes effect only from row 0 of the next frame.
- **Enable:**
  - Drop `enable` during row 2 ON: row 2 completes, then pins stay high and `row_addr`=0.
  - Re-raise `enable`: the scan resumes at row 0.
- **Fetch timing:**
  - Change `values` on the second BLANK cycle, then change again after sampling.
  - Only the value present on the last BLANK cycle is displayed.
